// File: rtl/int16_tmr_voter.sv
// Majority voter for three replicated adder lanes with lane-failure tracking.
// Degrades TMR -> DMR -> SIMPLEX -> DEAD as lanes accumulate consecutive misses.
module int16_tmr_voter #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] y0,
  input  logic [WORD_WIDTH-1:0] y1,
  input  logic [WORD_WIDTH-1:0] y2,
  input  logic                  cout0,
  input  logic                  cout1,
  input  logic                  cout2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] y,
  output logic                  cout,
  output logic                  mismatch,
  output logic                  uncorrectable,
  output logic                  fatal,
  output logic [2:0]            lane_failed,
  output logic [1:0]            mode,
  output logic [7:0]            err_count
);

  localparam int unsigned VW = WORD_WIDTH + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    MODE_TMR     = 2'b00,
    MODE_DMR     = 2'b01,
    MODE_SIMPLEX = 2'b10,
    MODE_DEAD    = 2'b11
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [VW-1:0]   lane_w [3];
  logic [CW-1:0]   miss_q [3];
  logic [CW-1:0]   miss_d [3];
  logic [VW-1:0]   maj, dmr_lo, dmr_hi, voted;
  logic            vote_mis, vote_unc, vote_upd;
  logic            accept;
  logic            ov_d, cout_d, mis_d, unc_d, fatal_d;
  logic [WORD_WIDTH-1:0] y_d;
  logic [2:0]      lf_d;
  logic [1:0]      fail_cnt;
  logic [7:0]      err_d;

  assign lane_w[0] = {cout0, y0};
  assign lane_w[1] = {cout1, y1};
  assign lane_w[2] = {cout2, y2};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode     = mode_q;

  // Vote using the mode held before this edge
  always_comb begin
    voted    = '0;
    vote_mis = 1'b0;
    vote_unc = 1'b0;
    vote_upd = 1'b0;
    maj      = (lane_w[0] & lane_w[1]) | (lane_w[0] & lane_w[2]) | (lane_w[1] & lane_w[2]);
    dmr_lo   = lane_failed[0] ? lane_w[1] : lane_w[0];
    dmr_hi   = lane_failed[2] ? lane_w[1] : lane_w[2];
    unique case (mode_q)
      MODE_TMR: begin
        voted    = maj;
        vote_mis = (lane_w[0] != maj) || (lane_w[1] != maj) || (lane_w[2] != maj);
        vote_upd = 1'b1;
      end
      MODE_DMR: begin
        voted = dmr_lo;
        if (dmr_lo == dmr_hi) begin
          vote_upd = 1'b1;
        end else begin
          vote_mis = 1'b1;
          vote_unc = 1'b1;
        end
      end
      MODE_SIMPLEX: begin
        voted = !lane_failed[0] ? lane_w[0] : (!lane_failed[1] ? lane_w[1] : lane_w[2]);
      end
      MODE_DEAD: begin
        voted = '0;
      end
    endcase
  end

  // Next-state for the output entry, miss counters and health state
  always_comb begin
    ov_d    = out_valid;
    y_d     = y;
    cout_d  = cout;
    mis_d   = mismatch;
    unc_d   = uncorrectable;
    fatal_d = fatal;
    lf_d    = lane_failed;
    err_d   = err_count;
    for (int i = 0; i < 3; i++) miss_d[i] = miss_q[i];

    if (accept) begin
      ov_d   = 1'b1;
      y_d    = voted[WORD_WIDTH-1:0];
      cout_d = voted[VW-1];
      mis_d  = vote_mis;
      unc_d  = vote_unc;
      if (vote_mis && err_count != 8'hFF) err_d = err_count + 8'd1;
      if (vote_upd) begin
        for (int i = 0; i < 3; i++) begin
          if (!lane_failed[i]) begin
            miss_d[i] = (lane_w[i] != voted) ? CW'(miss_q[i] + CW'(1)) : '0;
            if (miss_d[i] == CW'(FAIL_THRESH)) lf_d[i] = 1'b1;
          end
        end
      end
      fatal_d = fatal | (lf_d == 3'b111);
    end else if (out_ready) begin
      ov_d = 1'b0;
    end

    fail_cnt = 2'(lf_d[0]) + 2'(lf_d[1]) + 2'(lf_d[2]);
    mode_d   = mode_e'(fail_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      y             <= '0;
      cout          <= 1'b0;
      mismatch      <= 1'b0;
      uncorrectable <= 1'b0;
      fatal         <= 1'b0;
      lane_failed   <= 3'b000;
      mode_q        <= MODE_TMR;
      err_count     <= 8'd0;
      for (int i = 0; i < 3; i++) miss_q[i] <= '0;
    end else begin
      out_valid     <= ov_d;
      y             <= y_d;
      cout          <= cout_d;
      mismatch      <= mis_d;
      uncorrectable <= unc_d;
      fatal         <= fatal_d;
      lane_failed   <= lf_d;
      mode_q        <= mode_d;
      err_count     <= err_d;
      for (int i = 0; i < 3; i++) miss_q[i] <= miss_d[i];
    end
  end

endmodule

// File: tb/tb_int16_tmr_voter.sv
// Scoreboard bench for int16_tmr_voter: driver pushes model results on accept,
// monitor compares every presented output entry against the queue head.
module tb_int16_tmr_voter;

  localparam int unsigned W      = 16;
  localparam int unsigned THRESH = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout;
    logic         mis;
    logic         unc;
    logic         fatal;
    logic [2:0]   lf;
    logic [1:0]   mode;
    logic [7:0]   err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] y0 = '0, y1 = '0, y2 = '0;
  logic cout0 = 1'b0, cout1 = 1'b0, cout2 = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [W-1:0] y;
  logic cout, mismatch, uncorrectable, fatal;
  logic [2:0] lane_failed;
  logic [1:0] mode;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  bit   exp_ov = 1'b0;
  int   miss [3];
  bit   failed [3];
  int   err_m;

  always #5 clk = ~clk;

  int16_tmr_voter #(.WORD_WIDTH(W), .FAIL_THRESH(THRESH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2),
    .cout0(cout0), .cout1(cout1), .cout2(cout2),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .mismatch(mismatch), .uncorrectable(uncorrectable),
    .fatal(fatal), .lane_failed(lane_failed), .mode(mode), .err_count(err_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t a;
    a = '{y: y, cout: cout, mis: mismatch, unc: uncorrectable, fatal: fatal,
          lf: lane_failed, mode: mode, err: err_count};
    return a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      miss[i]   = 0;
      failed[i] = 1'b0;
    end
    err_m = 0;
  endfunction

  // Behavioural reference: count failed lanes, vote by per-bit popcount
  function automatic exp_t model(input logic [W:0] a, input logic [W:0] b, input logic [W:0] c);
    logic [W:0] w [3];
    logic [W:0] out;
    bit mis, unc, upd;
    int nf, ones;
    int h[$];
    exp_t e;
    w[0] = a; w[1] = b; w[2] = c;
    out = '0; mis = 0; unc = 0; upd = 0; nf = 0;
    for (int i = 0; i < 3; i++) if (!failed[i]) h.push_back(i); else nf++;
    case (nf)
      0: begin
        for (int k = 0; k <= W; k++) begin
          ones = int'(w[0][k]) + int'(w[1][k]) + int'(w[2][k]);
          out[k] = (ones >= 2);
        end
        for (int i = 0; i < 3; i++) if (w[i] != out) mis = 1;
        upd = 1;
      end
      1: begin
        out = w[h[0]];
        if (w[h[0]] == w[h[1]]) upd = 1;
        else begin mis = 1; unc = 1; end
      end
      2: out = w[h[0]];
      default: out = '0;
    endcase
    if (upd)
      for (int i = 0; i < 3; i++)
        if (!failed[i]) begin
          miss[i] = (w[i] != out) ? miss[i] + 1 : 0;
          if (miss[i] >= int'(THRESH)) failed[i] = 1'b1;
        end
    if (mis && err_m < 255) err_m++;
    nf = 0;
    for (int i = 0; i < 3; i++) if (failed[i]) nf++;
    e.y = out[W-1:0]; e.cout = out[W]; e.mis = mis; e.unc = unc;
    e.fatal = (nf == 3); e.lf = {failed[2], failed[1], failed[0]};
    e.mode = 2'(nf); e.err = 8'(err_m);
    return e;
  endfunction

  // One clock of stimulus; decides acceptance from the bench's own valid tracking
  task automatic cycle(input bit iv, input logic [W:0] a, input logic [W:0] b,
                       input logic [W:0] c, input bit orr);
    bit acc;
    @(posedge clk);
    #1;
    in_valid = iv;
    {cout0, y0} = a; {cout1, y1} = b; {cout2, y2} = c;
    out_ready = orr;
    #3;
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("in_ready", 64'(in_ready), 64'(!exp_ov || orr));
    acc = iv && (!exp_ov || orr);
    if (acc) sbq.push_back(model(a, b, c));
    exp_ov = acc || (exp_ov && !orr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'(dut_out()), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    out_ready = 1'b0;
    sbq.delete();
    model_reset();
    exp_ov = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  // Monitor: compare whenever an entry is presented, pop on transfer
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: out_valid with empty scoreboard at %0t", $time);
      end else begin
        check("beat", 64'(dut_out()), 64'(sbq[0]));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  logic [W:0] base, bad, l0, l1, l2;
  int p_bad [3];

  initial begin
    model_reset();
    do_reset();

    // Clean beat
    cycle(1, 17'h01234, 17'h01234, 17'h01234, 1);
    cycle(0, '0, '0, '0, 1);
    check("clean_y", 64'(y), 64'(16'h1234));
    check("clean_mis", 64'(mismatch), 64'(0));
    check("clean_err", 64'(err_count), 64'(0));

    // Lane 1 off by one for four beats -> lane 1 fails, DMR
    for (int k = 0; k < 4; k++) cycle(1, 17'h01234, 17'h01235, 17'h01234, 1);
    cycle(0, '0, '0, '0, 1);
    check("dmr_lf", 64'(lane_failed), 64'(3'b010));
    check("dmr_mode", 64'(mode), 64'(2'b01));
    check("dmr_err", 64'(err_count), 64'(4));

    // DMR disagreement
    cycle(1, 17'h0AAAA, 17'h00000, 17'h05555, 1);
    cycle(0, '0, '0, '0, 1);
    check("dmr_dis_y", 64'(y), 64'(16'hAAAA));
    check("dmr_dis_unc", 64'(uncorrectable), 64'(1));

    // Back-pressure: three stall cycles, then transfer + accept together
    cycle(1, 17'h00111, 17'h00111, 17'h00111, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 17'h00222, 17'h00222, 17'h00222, 0);
      check("stall_y", 64'(y), 64'(16'h0111));
    end
    cycle(1, 17'h00222, 17'h00222, 17'h00222, 1);
    cycle(0, '0, '0, '0, 1);
    check("after_stall_y", 64'(y), 64'(16'h0222));

    // Saturate err_count with recoverable lane-1 faults, then kill all lanes at once
    do_reset();
    for (int k = 0; k < 400; k++)
      cycle(1, 17'h00F0F, (k % 4 != 3) ? 17'h10F0F : 17'h00F0F, 17'h00F0F, 1);
    for (int k = 0; k < 3; k++) cycle(1, 17'h00000, 17'h00003, 17'h00005, 1);
    cycle(0, '0, '0, '0, 1);
    check("pre_dead_mode", 64'(mode), 64'(2'b00));
    cycle(1, 17'h00000, 17'h00003, 17'h00005, 1);
    cycle(0, '0, '0, '0, 1);
    check("dead_mode", 64'(mode), 64'(2'b11));
    check("dead_fatal", 64'(fatal), 64'(1));
    check("err_sat", 64'(err_count), 64'(255));
    for (int k = 0; k < 5; k++) cycle(1, 17'h1FFFF, 17'h1FFFF, 17'h0ABCD, 1);
    cycle(1, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 0);
    check("dead_y", 64'({cout, y}), 64'(0));
    cycle(1, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 0);
    do_reset();

    // Randomized runs with per-lane fault rates
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 3; i++) p_bad[i] = int'($urandom_range(0, 45));
      for (int k = 0; k < 250; k++) begin
        base = 17'($urandom);
        bad  = 17'($urandom);
        l0 = ($urandom_range(0, 99) < p_bad[0]) ? (($urandom_range(0, 1) != 0) ? bad : base ^ 17'(1 << $urandom_range(0, 16))) : base;
        l1 = ($urandom_range(0, 99) < p_bad[1]) ? (($urandom_range(0, 1) != 0) ? bad : base ^ 17'(1 << $urandom_range(0, 16))) : base;
        l2 = ($urandom_range(0, 99) < p_bad[2]) ? (($urandom_range(0, 1) != 0) ? bad : base ^ 17'(1 << $urandom_range(0, 16))) : base;
        cycle($urandom_range(0, 3) != 0, l0, l1, l2, $urandom_range(0, 9) < 7);
      end
      for (int k = 0; k < 4; k++) cycle(0, '0, '0, '0, 1);
      check("drain", 64'(sbq.size()), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
